// File: rtl/bridge_1x2_axi.sv
// bridge_1x2_axi: address-decoding 1-to-2 AXI demux.
// Routes one AXI master port (s_*) to memory (m0_*) or confreg (m1_*).
// One outstanding read and one outstanding write, each locked to its target
// until the transaction completes. Address/data fields are broadcast to both
// slaves; only valid/ready handshakes are steered.
// Optional feature macro: BRIDGE_1X2_TIMEOUT_EN (response-silence timeout that
// fakes a terminating response to the master).
module bridge_1x2_axi #(
    parameter logic [31:0] CONF_BASE = 32'h1faf_0000,
    parameter logic [31:0] CONF_MASK = 32'hffff_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        resetn,
    // master read address / data
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic        s_rlast,
    output logic        s_rvalid,
    input  logic        s_rready,
    // master write address / data / response
    input  logic [31:0] s_awaddr,
    input  logic [3:0]  s_awlen,
    input  logic [2:0]  s_awsize,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wlast,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic        s_bvalid,
    input  logic        s_bready,
    // slave 0: memory
    output logic [31:0] m0_araddr,
    output logic [3:0]  m0_arlen,
    output logic [2:0]  m0_arsize,
    output logic        m0_arvalid,
    input  logic        m0_arready,
    input  logic [31:0] m0_rdata,
    input  logic        m0_rlast,
    input  logic        m0_rvalid,
    output logic        m0_rready,
    output logic [31:0] m0_awaddr,
    output logic [3:0]  m0_awlen,
    output logic [2:0]  m0_awsize,
    output logic        m0_awvalid,
    input  logic        m0_awready,
    output logic [31:0] m0_wdata,
    output logic [3:0]  m0_wstrb,
    output logic        m0_wlast,
    output logic        m0_wvalid,
    input  logic        m0_wready,
    input  logic        m0_bvalid,
    output logic        m0_bready,
    // slave 1: confreg
    output logic [31:0] m1_araddr,
    output logic [3:0]  m1_arlen,
    output logic [2:0]  m1_arsize,
    output logic        m1_arvalid,
    input  logic        m1_arready,
    input  logic [31:0] m1_rdata,
    input  logic        m1_rlast,
    input  logic        m1_rvalid,
    output logic        m1_rready,
    output logic [31:0] m1_awaddr,
    output logic [3:0]  m1_awlen,
    output logic [2:0]  m1_awsize,
    output logic        m1_awvalid,
    input  logic        m1_awready,
    output logic [31:0] m1_wdata,
    output logic [3:0]  m1_wstrb,
    output logic        m1_wlast,
    output logic        m1_wvalid,
    input  logic        m1_wready,
    input  logic        m1_bvalid,
    output logic        m1_bready
);

`ifdef BRIDGE_1X2_TIMEOUT_EN
    typedef enum logic [1:0] {RIdle, RData, RFake} rd_state_e;
    typedef enum logic [2:0] {WIdle, WData, WResp, WFake} wr_state_e;
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);
`else
    typedef enum logic [0:0] {RIdle, RData} rd_state_e;
    typedef enum logic [1:0] {WIdle, WData, WResp} wr_state_e;
`endif

    rd_state_e r_rd_st, w_rd_st_next;
    wr_state_e r_wr_st, w_wr_st_next;
    logic      r_rd_sel, w_rd_sel_next;   // 1 = confreg
    logic      r_wr_sel, w_wr_sel_next;
    logic      w_ar_hit;
    logic      w_aw_hit;

    assign w_ar_hit = (s_araddr & CONF_MASK) == (CONF_BASE & CONF_MASK);
    assign w_aw_hit = (s_awaddr & CONF_MASK) == (CONF_BASE & CONF_MASK);

    // Address and write-data fields go to both slaves; valid gates them.
    assign m0_araddr = s_araddr;
    assign m0_arlen  = s_arlen;
    assign m0_arsize = s_arsize;
    assign m1_araddr = s_araddr;
    assign m1_arlen  = s_arlen;
    assign m1_arsize = s_arsize;
    assign m0_awaddr = s_awaddr;
    assign m0_awlen  = s_awlen;
    assign m0_awsize = s_awsize;
    assign m1_awaddr = s_awaddr;
    assign m1_awlen  = s_awlen;
    assign m1_awsize = s_awsize;
    assign m0_wdata  = s_wdata;
    assign m0_wstrb  = s_wstrb;
    assign m0_wlast  = s_wlast;
    assign m1_wdata  = s_wdata;
    assign m1_wstrb  = s_wstrb;
    assign m1_wlast  = s_wlast;

`ifdef BRIDGE_1X2_TIMEOUT_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;
    logic        w_rd_beat;
    logic        w_wr_beat;

    assign w_rd_beat = r_rd_sel ? m1_rvalid : m0_rvalid;
    assign w_wr_beat = r_wr_sel ? m1_bvalid : m0_bvalid;

    // Response-silence counters: cleared outside the waiting state or on any beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else begin
            if (r_rd_st != RData || w_rd_beat) begin
                r_rd_cnt <= 16'd0;
            end else if (r_rd_cnt != TO_LIMIT) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (r_wr_st != WResp || w_wr_beat) begin
                r_wr_cnt <= 16'd0;
            end else if (r_wr_cnt != TO_LIMIT) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    // State and target-lock registers for both channels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_st  <= RIdle;
            r_wr_st  <= WIdle;
            r_rd_sel <= 1'b0;
            r_wr_sel <= 1'b0;
        end else begin
            r_rd_st  <= w_rd_st_next;
            r_wr_st  <= w_wr_st_next;
            r_rd_sel <= w_rd_sel_next;
            r_wr_sel <= w_wr_sel_next;
        end
    end

    // Read channel: steer AR by decode while idle, then R from the locked target.
    always_comb begin
        w_rd_st_next  = r_rd_st;
        w_rd_sel_next = r_rd_sel;
        m0_arvalid    = 1'b0;
        m1_arvalid    = 1'b0;
        s_arready     = 1'b0;
        m0_rready     = 1'b0;
        m1_rready     = 1'b0;
        s_rvalid      = 1'b0;
        s_rdata       = r_rd_sel ? m1_rdata : m0_rdata;
        s_rlast       = r_rd_sel ? m1_rlast : m0_rlast;
        case (r_rd_st)
            RIdle: begin
                // Combinational path is gated so reset forces handshakes low.
                if (resetn) begin
                    if (w_ar_hit) begin
                        m1_arvalid = s_arvalid;
                        s_arready  = m1_arready;
                    end else begin
                        m0_arvalid = s_arvalid;
                        s_arready  = m0_arready;
                    end
                    if (s_arvalid && s_arready) begin
                        w_rd_st_next  = RData;
                        w_rd_sel_next = w_ar_hit;
                    end
                end
            end
            RData: begin
                s_rvalid = r_rd_sel ? m1_rvalid : m0_rvalid;
                if (r_rd_sel) begin
                    m1_rready = s_rready;
                end else begin
                    m0_rready = s_rready;
                end
                if (s_rvalid && s_rready && s_rlast) begin
                    w_rd_st_next = RIdle;
                end
`ifdef BRIDGE_1X2_TIMEOUT_EN
                else if (r_rd_cnt == TO_LIMIT) begin
                    w_rd_st_next = RFake;
                end
`endif
            end
`ifdef BRIDGE_1X2_TIMEOUT_EN
            RFake: begin
                // Slave went silent: terminate the burst toward the master.
                s_rvalid = 1'b1;
                s_rlast  = 1'b1;
                s_rdata  = 32'h0;
                if (s_rready) begin
                    w_rd_st_next = RIdle;
                end
            end
`endif
            default: w_rd_st_next = RIdle;
        endcase
    end

    // Write channel: AW steered while idle, then W and B to the locked target.
    always_comb begin
        w_wr_st_next  = r_wr_st;
        w_wr_sel_next = r_wr_sel;
        m0_awvalid    = 1'b0;
        m1_awvalid    = 1'b0;
        s_awready     = 1'b0;
        m0_wvalid     = 1'b0;
        m1_wvalid     = 1'b0;
        s_wready      = 1'b0;
        m0_bready     = 1'b0;
        m1_bready     = 1'b0;
        s_bvalid      = 1'b0;
        case (r_wr_st)
            WIdle: begin
                // W is held off here until the address is accepted.
                if (resetn) begin
                    if (w_aw_hit) begin
                        m1_awvalid = s_awvalid;
                        s_awready  = m1_awready;
                    end else begin
                        m0_awvalid = s_awvalid;
                        s_awready  = m0_awready;
                    end
                    if (s_awvalid && s_awready) begin
                        w_wr_st_next  = WData;
                        w_wr_sel_next = w_aw_hit;
                    end
                end
            end
            WData: begin
                if (r_wr_sel) begin
                    m1_wvalid = s_wvalid;
                    s_wready  = m1_wready;
                end else begin
                    m0_wvalid = s_wvalid;
                    s_wready  = m0_wready;
                end
                if (s_wvalid && s_wready && s_wlast) begin
                    w_wr_st_next = WResp;
                end
            end
            WResp: begin
                s_bvalid = r_wr_sel ? m1_bvalid : m0_bvalid;
                if (r_wr_sel) begin
                    m1_bready = s_bready;
                end else begin
                    m0_bready = s_bready;
                end
                if (s_bvalid && s_bready) begin
                    w_wr_st_next = WIdle;
                end
`ifdef BRIDGE_1X2_TIMEOUT_EN
                else if (r_wr_cnt == TO_LIMIT) begin
                    w_wr_st_next = WFake;
                end
`endif
            end
`ifdef BRIDGE_1X2_TIMEOUT_EN
            WFake: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    w_wr_st_next = WIdle;
                end
            end
`endif
            default: w_wr_st_next = WIdle;
        endcase
    end

endmodule

// File: tb/tb_bridge_1x2_axi.sv
// Testbench for bridge_1x2_axi: decode vector table, directed multi-cycle
// sequences, and randomized traffic against a transaction-level model.
module tb_bridge_1x2_axi;

    logic        clk;
    logic        resetn;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_arlen, s_awlen, s_wstrb;
    logic [2:0]  s_arsize, s_awsize;
    logic        s_arvalid, s_rready, s_awvalid, s_wlast, s_wvalid, s_bready;
    wire         s_arready, s_rlast, s_rvalid, s_awready, s_wready, s_bvalid;
    wire  [31:0] s_rdata;

    logic [1:0]  m_arready, m_rlast, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [31:0] m_rdata [2];
    wire  [1:0]  m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    wire  [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
    wire  [3:0]  m0_arlen, m1_arlen, m0_awlen, m1_awlen, m0_wstrb, m1_wstrb;
    wire  [2:0]  m0_arsize, m1_arsize, m0_awsize, m1_awsize;
    wire         m0_wlast, m1_wlast;

    int n_checks;
    int n_err;

    bridge_1x2_axi dut (
        .clk(clk), .resetn(resetn),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_rdata(m_rdata[0]), .m0_rlast(m_rlast[0]), .m0_rvalid(m_rvalid[0]),
        .m0_rready(m_rready[0]),
        .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
        .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
        .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_rdata(m_rdata[1]), .m1_rlast(m_rlast[1]), .m1_rvalid(m_rvalid[1]),
        .m1_rready(m_rready[1]),
        .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
        .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
        .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    wire [14:0] all_vr = {s_arready, s_rvalid, s_awready, s_wready, s_bvalid,
                          m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        m_arready = '0; m_rlast = '0; m_rvalid = '0; m_awready = '0; m_wready = '0;
        m_bvalid = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    function automatic int hit(input logic [31:0] a);
        return ((a & 32'hffff_0000) == 32'h1faf_0000) ? 1 : 0;
    endfunction

    // ---------------- transaction-level reference model ----------------
    // Owner of each channel: -1 = free, else target index. A write is either
    // still taking data or waiting for its response.
    int   rd_own, wr_own;
    bit   wr_resp;
    logic [1:0]  e_m_arvalid, e_m_rready, e_m_awvalid, e_m_wvalid, e_m_bready;
    logic        e_s_arready, e_s_rvalid, e_s_awready, e_s_wready, e_s_bvalid, e_rlast;
    logic [31:0] e_rdata;

    task automatic model_outputs();
        int ta, tw;
        ta = hit(s_araddr);
        tw = hit(s_awaddr);
        e_m_arvalid = '0; e_m_rready = '0; e_m_awvalid = '0; e_m_wvalid = '0; e_m_bready = '0;
        e_s_arready = 1'b0; e_s_rvalid = 1'b0; e_s_awready = 1'b0; e_s_wready = 1'b0;
        e_s_bvalid = 1'b0; e_rlast = 1'b0; e_rdata = '0;
        if (rd_own < 0) begin
            e_m_arvalid[ta] = s_arvalid;
            e_s_arready     = m_arready[ta];
        end else begin
            e_s_rvalid         = m_rvalid[rd_own];
            e_m_rready[rd_own] = s_rready;
            e_rdata            = m_rdata[rd_own];
            e_rlast            = m_rlast[rd_own];
        end
        if (wr_own < 0) begin
            e_m_awvalid[tw] = s_awvalid;
            e_s_awready     = m_awready[tw];
        end else if (!wr_resp) begin
            e_m_wvalid[wr_own] = s_wvalid;
            e_s_wready         = m_wready[wr_own];
        end else begin
            e_s_bvalid         = m_bvalid[wr_own];
            e_m_bready[wr_own] = s_bready;
        end
    endtask

    task automatic model_advance();
        if (rd_own < 0) begin
            if (s_arvalid && e_s_arready) rd_own = hit(s_araddr);
        end else if (e_s_rvalid && s_rready && e_rlast) begin
            rd_own = -1;
        end
        if (wr_own < 0) begin
            if (s_awvalid && e_s_awready) begin
                wr_own  = hit(s_awaddr);
                wr_resp = 1'b0;
            end
        end else if (!wr_resp) begin
            if (s_wvalid && e_s_wready && s_wlast) wr_resp = 1'b1;
        end else if (e_s_bvalid && s_bready) begin
            wr_own  = -1;
            wr_resp = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("rnd_m_arvalid", m_arvalid, e_m_arvalid);
        chk("rnd_s_arready", s_arready, e_s_arready);
        chk("rnd_m_rready", m_rready, e_m_rready);
        chk("rnd_s_rvalid", s_rvalid, e_s_rvalid);
        if (e_s_rvalid) begin
            chk("rnd_s_rdata", s_rdata, e_rdata);
            chk("rnd_s_rlast", s_rlast, e_rlast);
        end
        chk("rnd_m_awvalid", m_awvalid, e_m_awvalid);
        chk("rnd_s_awready", s_awready, e_s_awready);
        chk("rnd_m_wvalid", m_wvalid, e_m_wvalid);
        chk("rnd_s_wready", s_wready, e_s_wready);
        chk("rnd_s_bvalid", s_bvalid, e_s_bvalid);
        chk("rnd_m_bready", m_bready, e_m_bready);
        chk("rnd_ar_bcast", {m0_araddr, m0_arlen, m0_arsize, m1_araddr, m1_arlen, m1_arsize},
            {2{s_araddr, s_arlen, s_arsize}});
        chk("rnd_w_bcast", {m0_awaddr, m0_awlen, m0_awsize, m0_wdata, m0_wstrb, m0_wlast,
                            m1_awaddr, m1_awlen, m1_awsize, m1_wdata, m1_wstrb, m1_wlast},
            {2{s_awaddr, s_awlen, s_awsize, s_wdata, s_wstrb, s_wlast}});
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0:       a = 32'h1faf_0000 | 32'($urandom_range(0, 65535));
            1:       a = $urandom & 32'h0fff_ffff;
            2:       a = $urandom_range(0, 1) ? 32'h1fae_ffff : 32'h1fb0_0000;
            default: a = $urandom;
        endcase
        return a;
    endfunction

    // ---------------- decode vector table (both channels idle) ----------------
    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic        valid;
        logic [1:0]  rdy;
        logic [1:0]  e_mvalid;
        logic        e_sready;
    } vec_t;

    vec_t vecs [8];

    initial begin
        n_checks = 0;
        n_err    = 0;
        vecs[0] = '{1'b0, 32'h1faf_0000, 1'b1, 2'b10, 2'b10, 1'b1};
        vecs[1] = '{1'b0, 32'h1faf_ffff, 1'b1, 2'b01, 2'b10, 1'b0};
        vecs[2] = '{1'b0, 32'h1fae_ffff, 1'b1, 2'b01, 2'b01, 1'b1};
        vecs[3] = '{1'b0, 32'h1fb0_0000, 1'b1, 2'b10, 2'b01, 1'b0};
        vecs[4] = '{1'b0, 32'h9faf_1234, 1'b0, 2'b11, 2'b00, 1'b1};
        vecs[5] = '{1'b1, 32'h1faf_8000, 1'b1, 2'b10, 2'b10, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_1000, 1'b1, 2'b01, 2'b01, 1'b1};
        vecs[7] = '{1'b1, 32'h3faf_0000, 1'b1, 2'b10, 2'b01, 1'b0};

        // Reset: every valid/ready output low even with inputs asserted.
        clear_inputs();
        resetn = 1'b0;
        s_arvalid = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1; s_rready = 1'b1; s_bready = 1'b1;
        m_arready = 2'b11; m_awready = 2'b11; m_wready = 2'b11;
        m_rvalid = 2'b11; m_bvalid = 2'b11;
        #3;
        chk("reset_vr", all_vr, 15'd0);
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vecs[i].is_wr) begin
                s_awaddr = vecs[i].addr; s_awvalid = vecs[i].valid; m_awready = vecs[i].rdy;
                s_wvalid = 1'b1; m_wready = 2'b11;
                settle();
                chk($sformatf("tbl%0d_m_awvalid", i), m_awvalid, vecs[i].e_mvalid);
                chk($sformatf("tbl%0d_s_awready", i), s_awready, vecs[i].e_sready);
                chk($sformatf("tbl%0d_s_wready", i), s_wready, 1'b0);
                chk($sformatf("tbl%0d_m_wvalid", i), m_wvalid, 2'b00);
            end else begin
                s_araddr = vecs[i].addr; s_arvalid = vecs[i].valid; m_arready = vecs[i].rdy;
                settle();
                chk($sformatf("tbl%0d_m_arvalid", i), m_arvalid, vecs[i].e_mvalid);
                chk($sformatf("tbl%0d_s_arready", i), s_arready, vecs[i].e_sready);
            end
            settle();
            clear_inputs();
        end

        // Single-beat read from confreg; idle again the cycle after rlast.
        cyc();
        s_araddr = 32'h1faf_f000; s_arlen = 4'd0; s_arsize = 3'd2; s_arvalid = 1'b1;
        m_arready = 2'b10;
        settle();
        chk("t1_m_arvalid", m_arvalid, 2'b10);
        chk("t1_s_arready", s_arready, 1'b1);
        cyc();
        m_arready = 2'b11; m_rvalid = 2'b11; m_rlast = 2'b11; s_rready = 1'b1;
        m_rdata[0] = 32'hdead_beef; m_rdata[1] = 32'h1234_5678;
        settle();
        chk("t1_data_s_arready", s_arready, 1'b0);
        chk("t1_data_m_arvalid", m_arvalid, 2'b00);
        chk("t1_s_rvalid", s_rvalid, 1'b1);
        chk("t1_s_rdata", s_rdata, 32'h1234_5678);
        chk("t1_s_rlast", s_rlast, 1'b1);
        chk("t1_m_rready", m_rready, 2'b10);
        cyc();
        m_rvalid = 2'b00; m_rlast = 2'b00;
        settle();
        chk("t1_idle_m_arvalid", m_arvalid, 2'b10);
        chk("t1_idle_s_rvalid", s_rvalid, 1'b0);
        chk("t1_idle_m_rready", m_rready, 2'b00);
        clear_inputs();

        // W offered before AW: held off until the address handshake.
        cyc();
        s_wvalid = 1'b1; s_wstrb = 4'hf; m_wready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("t3_early%0d_s_wready", k), s_wready, 1'b0);
            chk($sformatf("t3_early%0d_m_wvalid", k), m_wvalid, 2'b00);
            cyc();
        end
        s_awaddr = 32'h0000_1000; s_awlen = 4'd3; s_awsize = 3'd2; s_awvalid = 1'b1;
        m_awready = 2'b01;
        settle();
        chk("t3_aw_s_wready", s_wready, 1'b0);
        chk("t3_m_awvalid", m_awvalid, 2'b01);
        chk("t3_s_awready", s_awready, 1'b1);
        cyc();
        s_awvalid = 1'b0;

        // Four-beat write to memory with m0_wready toggling.
        begin
            int beats;
            beats = 0;
            for (int c = 0; c < 20 && beats < 4; c++) begin
                m_wready = {1'b1, c[0]};
                s_wvalid = 1'b1; s_wlast = (beats == 3); s_wdata = 32'ha000_0000 + 32'(beats);
                settle();
                chk("t2_m1_wvalid", m_wvalid[1], 1'b0);
                chk("t2_s_bvalid", s_bvalid, 1'b0);
                chk("t2_s_wready", s_wready, m_wready[0]);
                if (m_wvalid[0] && m_wready[0]) beats++;
                cyc();
            end
            chk("t2_beats", beats, 4);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0; m_bvalid = 2'b10; s_bready = 1'b1;
        settle();
        chk("t2_wait_s_bvalid", s_bvalid, 1'b0);
        chk("t2_wait_m_bready", m_bready, 2'b01);
        chk("t2_resp_s_wready", s_wready, 1'b0);
        cyc();
        m_bvalid = 2'b01;
        settle();
        chk("t2_s_bvalid", s_bvalid, 1'b1);
        chk("t2_m_bready", m_bready, 2'b01);
        cyc();
        m_bvalid = 2'b00;
        settle();
        chk("t2_done_s_bvalid", s_bvalid, 1'b0);
        chk("t2_done_m_bready", m_bready, 2'b00);
        clear_inputs();

        // Reset asserted during beat 2 of an 8-beat read.
        cyc();
        s_araddr = 32'h0000_2000; s_arlen = 4'd7; s_arvalid = 1'b1; m_arready = 2'b01;
        settle();
        chk("t5_s_arready", s_arready, 1'b1);
        cyc();
        s_arvalid = 1'b0; m_rvalid = 2'b01; m_rlast = 2'b00; s_rready = 1'b1;
        cyc();
        settle();
        chk("t5_beat2_s_rvalid", s_rvalid, 1'b1);
        s_arvalid = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        m_arready = 2'b11; m_awready = 2'b11; m_wready = 2'b11; m_bvalid = 2'b11;
        #1;
        resetn = 1'b0;
        #1;
        chk("t5_reset_vr", all_vr, 15'd0);
        cyc();
        cyc();
        clear_inputs();
        @(negedge clk);
        resetn = 1'b1;
        s_araddr = 32'h1faf_0040; s_arvalid = 1'b1; m_arready = 2'b10;
        settle();
        chk("t5_new_s_arready", s_arready, 1'b1);
        chk("t5_new_m_arvalid", m_arvalid, 2'b10);
        cyc();
        s_arvalid = 1'b0;
        settle();
        chk("t5_locked_s_arready", s_arready, 1'b0);

        // Randomized overlapping traffic against the model.
        cyc();
        resetn = 1'b0;
        clear_inputs();
        cyc();
        @(negedge clk);
        resetn = 1'b1;
        rd_own = -1; wr_own = -1; wr_resp = 1'b0;
        cyc();
        for (int c = 0; c < 3000; c++) begin
            s_araddr  = rand_addr();      s_awaddr = rand_addr();
            s_arlen   = 4'($urandom);     s_awlen  = 4'($urandom);
            s_arsize  = 3'($urandom);     s_awsize = 3'($urandom);
            s_wdata   = $urandom;         s_wstrb  = 4'($urandom);
            s_arvalid = 1'($urandom);     s_awvalid = 1'($urandom);
            s_wvalid  = 1'($urandom);     s_wlast  = ($urandom_range(0, 2) == 0);
            s_rready  = 1'($urandom);     s_bready = 1'($urandom);
            m_arready = 2'($urandom);     m_awready = 2'($urandom);
            m_wready  = 2'($urandom);     m_rvalid = 2'($urandom);
            m_bvalid  = 2'($urandom);
            m_rlast   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            m_rdata[0] = $urandom;        m_rdata[1] = $urandom;
            settle();
            model_outputs();
            check_all();
            model_advance();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
